cbus_sram_responder: RTL and testbench

//  Cache-bus (cbus) responder backed by an on-chip 64-bit-word SRAM. It is the far end of the

---
 rtl/cbus_sram_responder_pkg.sv | 40 ++++
 rtl/cbus_sram_responder_ram.sv | 42 ++++
 rtl/cbus_sram_responder.sv | 154 +++++++++++++++
 tb/tb_cbus_sram_responder.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbus_sram_responder_pkg.sv
// Cache-bus request/response types and encodings shared by cbus initiators and responders.
package cbus_sram_responder_pkg;

  typedef logic [2:0] msize_t;
  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  // Burst length encoded as beats-1.
  typedef logic [3:0] mlen_t;
  localparam mlen_t MLEN1  = 4'd0;
  localparam mlen_t MLEN2  = 4'd1;
  localparam mlen_t MLEN4  = 4'd3;
  localparam mlen_t MLEN8  = 4'd7;
  localparam mlen_t MLEN16 = 4'd15;

  typedef logic [1:0] axi_burst_type_t;
  localparam axi_burst_type_t AXI_BURST_FIXED = 2'd0;
  localparam axi_burst_type_t AXI_BURST_INCR  = 2'd1;
  localparam axi_burst_type_t AXI_BURST_WRAP  = 2'd2;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    logic [63:0]     addr;
    logic [7:0]      strobe;
    logic [63:0]     data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_sram_responder_ram.sv
// Single-port byte-writable SRAM. Contents are never reset.
module RAM_SinglePort #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic                           clk,
  input  logic                           i_en,
  input  logic [ADDR_WIDTH-1:0]          i_addr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_strobe,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  output logic [DATA_WIDTH-1:0]          o_rdata
);

  localparam int unsigned NumBytes = DATA_WIDTH / BYTE_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  // Byte-masked write of the addressed word.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (i_strobe[i]) begin
          r_mem[i_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= i_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  if (READ_LATENCY == 0) begin : g_comb_rd
    assign o_rdata = r_mem[i_addr];
  end else begin : g_reg_rd
    logic [DATA_WIDTH-1:0] r_rdata;
    // Registered read port.
    always_ff @(posedge clk) begin
      r_rdata <= r_mem[i_addr];
    end
    assign o_rdata = r_rdata;
  end

endmodule

// File: rtl/cbus_sram_responder.sv
// Cache-bus responder backed by a 64-bit-word SRAM. Serves single and burst reads/writes
// after a configurable first-beat latency.
// Optional feature: define CBUS_SRAM_WRAP_EN to give AXI_BURST_WRAP true wrapping semantics;
// otherwise WRAP bursts behave as INCR.
module cbus_sram_responder
  import cbus_sram_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);
  localparam int unsigned CntW = $clog2(LATENCY + 2);

  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_wait_cnt, w_wait_d;
  mlen_t           r_beat, w_beat_d;
  logic            r_is_write;
  idx_t            r_start;
  mlen_t           r_len;
  axi_burst_type_t r_burst;

  logic            w_ready;
  logic            w_wr_en;
  idx_t            w_idx;
  idx_t            w_incr_idx;
  logic [63:0]     w_rdata;

  // Size and sub-word/aliased address bits do not affect the responder.
  logic w_unused_req;
  assign w_unused_req = ^{creq.size, creq.addr[2:0], creq.addr[63:3+IdxW]};

  // State and counter registers; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_wait_cnt <= '0;
      r_beat     <= '0;
    end else begin
      r_state    <= w_state_d;
      r_wait_cnt <= w_wait_d;
      r_beat     <= w_beat_d;
    end
  end

  // Latch the transaction attributes in the capture cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_write <= 1'b0;
      r_start    <= '0;
      r_len      <= MLEN1;
      r_burst    <= AXI_BURST_INCR;
    end else if (r_state == StIdle && creq.valid) begin
      r_is_write <= creq.is_write;
      r_start    <= creq.addr[3 +: IdxW];
      r_len      <= creq.len;
      r_burst    <= creq.burst;
    end
  end

  // Next-state logic; a dropped valid outside IDLE returns straight to IDLE.
  always_comb begin
    w_state_d = r_state;
    w_wait_d  = r_wait_cnt;
    w_beat_d  = r_beat;
    w_ready   = 1'b0;
    case (r_state)
      StIdle: begin
        if (creq.valid) begin
          w_wait_d  = CntW'(LATENCY);
          w_beat_d  = '0;
          w_state_d = (LATENCY == 0) ? StBurst : StWait;
        end
      end
      StWait: begin
        if (!creq.valid) begin
          w_state_d = StIdle;
        end else begin
          w_wait_d = r_wait_cnt - CntW'(1);
          if (r_wait_cnt <= CntW'(1)) w_state_d = StBurst;
        end
      end
      StBurst: begin
        if (!creq.valid) begin
          w_state_d = StIdle;
        end else begin
          w_ready = 1'b1;
          if (r_beat == r_len) begin
            w_beat_d  = '0;
            w_state_d = StIdle;
          end else begin
            w_beat_d = r_beat + mlen_t'(1);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

`ifdef CBUS_SRAM_WRAP_EN
  idx_t w_len_mask;
  logic w_len_pow2;
  assign w_len_mask = idx_t'(r_len);
  // Only power-of-two beat counts form an aligned wrap window.
  assign w_len_pow2 = ((r_len & mlen_t'(r_len + mlen_t'(1))) == '0);
`endif

  // Beat index from the latched start word and burst type.
  always_comb begin
    w_incr_idx = r_start + idx_t'(r_beat);
    w_idx      = w_incr_idx;
    if (r_burst == AXI_BURST_FIXED) begin
      w_idx = r_start;
    end
`ifdef CBUS_SRAM_WRAP_EN
    else if (r_burst == AXI_BURST_WRAP && w_len_pow2) begin
      w_idx = (r_start & ~w_len_mask) | (w_incr_idx & w_len_mask);
    end
`endif
  end

  assign w_wr_en = w_ready && r_is_write;

  RAM_SinglePort #(
    .ADDR_WIDTH  (IdxW),
    .DATA_WIDTH  (64),
    .BYTE_WIDTH  (8),
    .READ_LATENCY(0)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_wr_en),
    .i_addr  (w_idx),
    .i_strobe(creq.strobe),
    .i_wdata (creq.data),
    .o_rdata (w_rdata)
  );

  // Response: read data only on read beats, zero otherwise.
  always_comb begin
    cresp       = '0;
    cresp.ready = w_ready;
    cresp.last  = w_ready && (r_beat == r_len);
    cresp.data  = (w_ready && !r_is_write) ? w_rdata : 64'h0;
  end

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Self-checking bench for cbus_sram_responder with a word-array reference model.
module tb_cbus_sram_responder;
  import cbus_sram_responder_pkg::*;

  localparam int unsigned WORDS = 4096;
  localparam int unsigned LAT   = 2;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] model_mem [WORDS];
  logic [7:0]  tx_strb [16];
  logic [63:0] tx_data [16];
  logic [63:0] obs_data [17];
  logic        obs_last [17];
  int          obs_n;
  int          obs_first;
  logic        obs_to;

  cbus_sram_responder #(
    .MEM_WORDS(WORDS),
    .LATENCY  (LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .creq (creq),
    .cresp(cresp)
  );

  always #5 clk = ~clk;

  function automatic int unsigned model_idx(input int unsigned start, input int unsigned len,
                                            input logic [1:0] burst, input int unsigned b);
    int unsigned n;
    n = len + 1;
    if (burst == AXI_BURST_FIXED) return start;
`ifdef CBUS_SRAM_WRAP_EN
    if (burst == AXI_BURST_WRAP && (n & (n - 1)) == 0) return (start - start % n) + (start + b) % n;
`endif
    return (start + b) % WORDS;
  endfunction

  task automatic model_write(input logic [63:0] addr, input int unsigned len,
                             input logic [1:0] burst, input int unsigned nbeats);
    int unsigned idx;
    for (int b = 0; b < nbeats; b++) begin
      idx = model_idx(addr[14:3], len, burst, b);
      for (int i = 0; i < 8; i++)
        if (tx_strb[b][i]) model_mem[idx][8*i +: 8] = tx_data[b][8*i +: 8];
    end
  endtask

  // Drives one transaction starting in an IDLE cycle; records every beat.
  task automatic run_txn(input logic wr, input logic [63:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input logic hold);
    int  k;
    bit  done;
    creq.valid = 1'b1; creq.is_write = wr; creq.size = MSIZE8; creq.addr = addr;
    creq.len = len; creq.burst = burst; creq.strobe = 8'h00; creq.data = 64'h0;
    obs_n = 0; obs_first = -1; obs_to = 1'b0; k = 0; done = 1'b0;
    while (!done) begin
      @(posedge clk); #1; k++;
      if (cresp.ready) begin
        if (obs_first < 0) obs_first = k;
        if (obs_n < 16) begin
          creq.data = tx_data[obs_n]; creq.strobe = tx_strb[obs_n];
        end
        obs_data[obs_n] = cresp.data; obs_last[obs_n] = cresp.last; obs_n++;
        if (cresp.last || obs_n >= 17) done = 1'b1;
      end
      if (k >= 100) begin obs_to = 1'b1; done = 1'b1; end
    end
    @(posedge clk); #1;
    if (!hold || obs_to) begin
      creq.valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; creq = '0;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (cresp !== '0) begin
      n_errors++; $display("FAIL reset_resp: got %h expected 0", cresp);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (cresp !== '0) begin
      n_errors++; $display("FAIL idle_resp: got %h expected 0", cresp);
    end
  endtask

  task automatic fill_mem;
    for (int w = 0; w < WORDS; w += 16) begin
      for (int b = 0; b < 16; b++) begin
        tx_strb[b] = 8'hFF; tx_data[b] = {$urandom, $urandom};
      end
      run_txn(1'b1, 64'(w * 8), MLEN16, AXI_BURST_INCR, 1'b1);
      model_write(64'(w * 8), 15, AXI_BURST_INCR, 16);
    end
    creq.valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read;
    tx_strb[0] = 8'hFF; tx_data[0] = 64'hDEADBEEF_01234567;
    run_txn(1'b1, 64'h8000_0008, MLEN1, AXI_BURST_INCR, 1'b0);
    model_write(64'h8000_0008, 0, AXI_BURST_INCR, 1);
    run_txn(1'b0, 64'h8000_0008, MLEN1, AXI_BURST_INCR, 1'b0);
    n_checks++;
    if (obs_to !== 1'b0 || obs_n != 1) begin
      n_errors++; $display("FAIL single_beats: got %0d beats (timeout %0b) expected 1", obs_n, obs_to);
    end
    n_checks++;
    if (obs_first != 3) begin
      n_errors++; $display("FAIL single_latency: got %0d expected 3", obs_first);
    end
    n_checks++;
    if (obs_last[0] !== 1'b1 || obs_data[0] !== 64'hDEADBEEF_01234567) begin
      n_errors++;
      $display("FAIL single_data: got last %b data %h expected 1 deadbeef01234567",
               obs_last[0], obs_data[0]);
    end
  endtask

  task automatic test_incr_burst;
    for (int b = 0; b < 16; b++) begin tx_strb[b] = 8'hFF; tx_data[b] = 64'(b); end
    run_txn(1'b1, 64'h8000_0040, MLEN16, AXI_BURST_INCR, 1'b0);
    model_write(64'h8000_0040, 15, AXI_BURST_INCR, 16);
    n_checks++;
    if (obs_n != 16 || obs_data[0] !== 64'h0) begin
      n_errors++; $display("FAIL incr_wr_beats: got %0d beats data0 %h expected 16 0", obs_n, obs_data[0]);
    end
    run_txn(1'b0, 64'h8000_0040, MLEN16, AXI_BURST_INCR, 1'b0);
    n_checks++;
    if (obs_n != 16) begin
      n_errors++; $display("FAIL incr_rd_beats: got %0d expected 16", obs_n);
    end
    for (int b = 0; b < 16 && b < obs_n; b++) begin
      n_checks++;
      if (obs_data[b] !== 64'(b) || obs_last[b] !== (b == 15)) begin
        n_errors++;
        $display("FAIL incr_rd_beat%0d: got data %h last %b expected %h %b", b, obs_data[b],
                 obs_last[b], 64'(b), (b == 15));
      end
    end
  endtask

  task automatic test_strobe;
    tx_strb[0] = 8'hFF; tx_data[0] = 64'h11111111_22222222;
    run_txn(1'b1, 64'h0000_0300, MLEN1, AXI_BURST_INCR, 1'b0);
    tx_strb[0] = 8'h0F; tx_data[0] = 64'hAAAAAAAA_BBBBBBBB;
    run_txn(1'b1, 64'h0000_0300, MLEN1, AXI_BURST_INCR, 1'b0);
    model_mem[96] = 64'h11111111_BBBBBBBB;
    run_txn(1'b0, 64'h0000_0300, MLEN1, AXI_BURST_INCR, 1'b0);
    n_checks++;
    if (obs_n != 1 || obs_data[0] !== 64'h11111111_BBBBBBBB) begin
      n_errors++; $display("FAIL strobe_merge: got %h (%0d beats) expected 11111111bbbbbbbb",
                           obs_data[0], obs_n);
    end
  endtask

  task automatic test_back_to_back;
    for (int b = 0; b < 16; b++) begin tx_strb[b] = 8'hFF; tx_data[b] = {$urandom, $urandom}; end
    run_txn(1'b1, 64'h0000_0800, MLEN16, AXI_BURST_INCR, 1'b1);
    model_write(64'h0000_0800, 15, AXI_BURST_INCR, 16);
    run_txn(1'b0, 64'h0000_0800, MLEN16, AXI_BURST_INCR, 1'b0);
    n_checks++;
    if (obs_n != 16 || obs_first != LAT + 1) begin
      n_errors++; $display("FAIL b2b_read: got %0d beats first %0d expected 16 %0d",
                           obs_n, obs_first, LAT + 1);
    end
    for (int b = 0; b < 16 && b < obs_n; b++) begin
      n_checks++;
      if (obs_data[b] !== model_mem[256 + b]) begin
        n_errors++; $display("FAIL b2b_beat%0d: got %h expected %h", b, obs_data[b], model_mem[256 + b]);
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    int k, nb;
    k = 0; nb = 0;
    for (int b = 0; b < 16; b++) begin tx_strb[b] = 8'hFF; tx_data[b] = {$urandom, $urandom}; end
    creq.valid = 1'b1; creq.is_write = 1'b1; creq.addr = 64'h0000_1000; creq.len = MLEN16;
    creq.burst = AXI_BURST_INCR; creq.size = MSIZE8;
    while (k < 100) begin
      @(posedge clk); #1; k++;
      if (cresp.ready) begin
        if (nb == 5) begin
          reset = 1'b1;
          #1;
          n_checks++;
          if (cresp !== '0) begin
            n_errors++; $display("FAIL reset_mid_resp: got %h expected 0", cresp);
          end
          break;
        end
        creq.data = tx_data[nb]; creq.strobe = tx_strb[nb]; nb++;
      end
    end
    n_checks++;
    if (nb != 5) begin
      n_errors++; $display("FAIL reset_mid_reach: got %0d beats expected 5", nb);
    end
    model_write(64'h0000_1000, 15, AXI_BURST_INCR, 5);
    creq.valid = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    run_txn(1'b0, 64'h0000_1000, MLEN16, AXI_BURST_INCR, 1'b0);
    n_checks++;
    if (obs_n != 16 || obs_first != LAT + 1) begin
      n_errors++; $display("FAIL reset_next_req: got %0d beats first %0d expected 16 %0d",
                           obs_n, obs_first, LAT + 1);
    end
    for (int b = 0; b < 16 && b < obs_n; b++) begin
      n_checks++;
      if (obs_data[b] !== model_mem[512 + b]) begin
        n_errors++; $display("FAIL reset_line%0d: got %h expected %h", b, obs_data[b], model_mem[512 + b]);
      end
    end
  endtask

  task automatic test_valid_drop;
    int k, nb;
    k = 0; nb = 0;
    creq.valid = 1'b1; creq.is_write = 1'b0; creq.addr = 64'h0000_2000; creq.len = MLEN16;
    creq.burst = AXI_BURST_INCR;
    while (k < 100 && nb < 3) begin
      @(posedge clk); #1; k++;
      if (cresp.ready) nb++;
    end
    creq.valid = 1'b0;
    #1;
    n_checks++;
    if (cresp.ready !== 1'b0 || cresp.data !== 64'h0 || nb != 3) begin
      n_errors++; $display("FAIL drop_ready: got ready %b data %h beats %0d expected 0 0 3",
                           cresp.ready, cresp.data, nb);
    end
    @(posedge clk); #1;
    run_txn(1'b0, 64'h0000_2008, MLEN1, AXI_BURST_INCR, 1'b0);
    n_checks++;
    if (obs_first != LAT + 1 || obs_data[0] !== model_mem[1025]) begin
      n_errors++; $display("FAIL drop_next: got first %0d data %h expected %0d %h",
                           obs_first, obs_data[0], LAT + 1, model_mem[1025]);
    end
  endtask

  task automatic test_burst_modes;
    int exp_wrap [4];
`ifdef CBUS_SRAM_WRAP_EN
    exp_wrap = '{6, 7, 4, 5};
`else
    exp_wrap = '{6, 7, 8, 9};
`endif
    for (int b = 0; b < 8; b++) begin tx_strb[b] = 8'hFF; tx_data[b] = 64'h600 + 64'(4 + b); end
    run_txn(1'b1, 64'h0000_0020, MLEN8, AXI_BURST_INCR, 1'b0);
    model_write(64'h0000_0020, 7, AXI_BURST_INCR, 8);
    run_txn(1'b0, 64'h0000_0030, MLEN4, AXI_BURST_WRAP, 1'b0);
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (obs_n != 4 || obs_data[b] !== 64'h600 + 64'(exp_wrap[b])) begin
        n_errors++; $display("FAIL wrap_beat%0d: got %h (%0d beats) expected %h", b, obs_data[b],
                             obs_n, 64'h600 + 64'(exp_wrap[b]));
      end
    end
    run_txn(1'b0, 64'h0000_0030, MLEN4, AXI_BURST_FIXED, 1'b0);
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (obs_n != 4 || obs_data[b] !== 64'h606) begin
        n_errors++; $display("FAIL fixed_beat%0d: got %h (%0d beats) expected 606", b, obs_data[b], obs_n);
      end
    end
  endtask

  task automatic test_random;
    logic [3:0]  lens [7];
    logic [3:0]  len;
    logic [1:0]  burst;
    logic [63:0] addr, expd;
    logic        wr;
    int unsigned idx;
    lens = '{4'd0, 4'd1, 4'd3, 4'd7, 4'd15, 4'd2, 4'd5};
    for (int t = 0; t < 60; t++) begin
      wr = 1'($urandom_range(0, 1));
      len = lens[$urandom_range(0, 6)];
      burst = 2'($urandom_range(0, 2));
      addr = {$urandom, $urandom};
      for (int b = 0; b < 16; b++) begin
        tx_strb[b] = 8'($urandom); tx_data[b] = {$urandom, $urandom};
      end
      run_txn(wr, addr, len, burst, 1'($urandom_range(0, 1)));
      n_checks++;
      if (obs_to !== 1'b0 || obs_n != int'(len) + 1 || obs_first != LAT + 1) begin
        n_errors++; $display("FAIL rand%0d_shape: got beats %0d first %0d to %b expected %0d %0d 0",
                             t, obs_n, obs_first, obs_to, int'(len) + 1, LAT + 1);
      end
      for (int b = 0; b <= int'(len) && b < obs_n; b++) begin
        idx = model_idx(addr[14:3], len, burst, b);
        expd = wr ? 64'h0 : model_mem[idx];
        n_checks++;
        if (obs_data[b] !== expd || obs_last[b] !== (b == int'(len))) begin
          n_errors++; $display("FAIL rand%0d_beat%0d: got %h last %b expected %h %b", t, b,
                               obs_data[b], obs_last[b], expd, (b == int'(len)));
        end
      end
      if (wr) model_write(addr, len, burst, int'(len) + 1);
    end
    creq.valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    fill_mem();
    test_single_read();
    test_incr_burst();
    test_strobe();
    test_back_to_back();
    test_reset_mid_burst();
    test_valid_drop();
    test_burst_modes();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
